// File: rtl/multi_pipe_param_if.sv
// Handshake bundle for multi_pipe_param: operand/valid/ready in, product/valid/ready out.
interface multi_pipe_param_if #(
    parameter int WIDTH = 8
);
    logic               mul_en_in;
    logic               mul_rdy_in;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_signed;
    logic               mul_en_out;
    logic               mul_out_rdy;
    logic [2*WIDTH-1:0] mul_out;

    modport master (
        output mul_en_in, mul_a, mul_b, mul_signed, mul_out_rdy,
        input  mul_rdy_in, mul_en_out, mul_out
    );

    modport slave (
        input  mul_en_in, mul_a, mul_b, mul_signed, mul_out_rdy,
        output mul_rdy_in, mul_en_out, mul_out
    );
endinterface

// File: rtl/multi_pipe_param.sv
// Four-stage pipelined shift-add multiplier WIDTH x WIDTH -> 2*WIDTH with valid/ready and stall.
// Signed mode is honoured only when MULTI_PIPE_SIGNED_EN is defined; otherwise all ops are unsigned.
module multi_pipe_param #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    multi_pipe_param_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int NP = WIDTH / 2;

    logic             stall, adv, take;
    logic             vld_p1, vld_p2, vld_p3, vld_p4;
    logic [WIDTH-1:0] a_p1, b_p1;
    logic [PW-1:0]    a_ext, top_pp;
    logic [PW-1:0]    pair_d  [NP];
    logic [PW-1:0]    pair_p2 [NP];
    logic [PW-1:0]    sum_d, sum_p3, out_p4;

    function automatic logic [PW-1:0] pp(input logic [PW-1:0] a, input logic bit_b, input int sh);
        return bit_b ? (a << sh) : '0;
    endfunction

    // The whole pipe advances together; a held output freezes every stage.
    assign stall          = vld_p4 && !bus.mul_out_rdy;
    assign adv            = !stall;
    assign take           = bus.mul_en_in && adv;
    assign bus.mul_rdy_in = adv;

    // S1: operand capture; bubbles carry zero data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
        end else if (adv) begin
            vld_p1 <= take;
            a_p1   <= take ? bus.mul_a : '0;
            b_p1   <= take ? bus.mul_b : '0;
        end
    end

`ifdef MULTI_PIPE_SIGNED_EN
    logic sgn_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sgn_p1 <= 1'b0;
        end else if (adv) begin
            sgn_p1 <= take ? bus.mul_signed : 1'b0;
        end
    end

    // Signed: sign-extend a and give the MSB of b a negative weight.
    always_comb begin
        a_ext  = {{WIDTH{sgn_p1 & a_p1[WIDTH-1]}}, a_p1};
        top_pp = pp(a_ext, b_p1[WIDTH-1], WIDTH - 1);
        if (sgn_p1) top_pp = -top_pp;
    end
`else
    logic unused_signed;
    assign unused_signed = bus.mul_signed;

    always_comb begin
        a_ext  = {{WIDTH{1'b0}}, a_p1};
        top_pp = pp(a_ext, b_p1[WIDTH-1], WIDTH - 1);
    end
`endif

    // S2: partial products summed in pairs
    always_comb begin
        for (int j = 0; j < NP - 1; j++) begin
            pair_d[j] = pp(a_ext, b_p1[2*j], 2*j) + pp(a_ext, b_p1[2*j+1], 2*j + 1);
        end
        pair_d[NP-1] = pp(a_ext, b_p1[WIDTH-2], WIDTH - 2) + top_pp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            for (int j = 0; j < NP; j++) pair_p2[j] <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            for (int j = 0; j < NP; j++) pair_p2[j] <= pair_d[j];
        end
    end

    // S3: reduce pair sums to the full product
    always_comb begin
        sum_d = '0;
        for (int j = 0; j < NP; j++) sum_d = sum_d + pair_p2[j];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p3 <= 1'b0;
            sum_p3 <= '0;
        end else if (adv) begin
            vld_p3 <= vld_p2;
            sum_p3 <= sum_d;
        end
    end

    // S4: output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p4 <= 1'b0;
            out_p4 <= '0;
        end else if (adv) begin
            vld_p4 <= vld_p3;
            out_p4 <= sum_p3;
        end
    end

    assign bus.mul_en_out = vld_p4;
    assign bus.mul_out    = vld_p4 ? out_p4 : '0;
endmodule

// File: tb/tb_multi_pipe_param.sv
// Scoreboard bench for multi_pipe_param: WIDTH 8 main pipe plus WIDTH 4 and 16 spot checks.
module tb_multi_pipe_param;
`ifdef MULTI_PIPE_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_pipe_param_if #(.WIDTH(8))  bus   ();
    multi_pipe_param_if #(.WIDTH(4))  bus4  ();
    multi_pipe_param_if #(.WIDTH(16)) bus16 ();

    multi_pipe_param #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    multi_pipe_param #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    multi_pipe_param #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int stall_cnt = 0;
    logic [15:0] exp_q [$];
    logic        was_stall = 1'b0;
    logic [15:0] held = '0;

    logic [7:0]  ta [16] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'hFF, 8'h01, 8'h80,
                             8'h12, 8'hAA, 8'h64, 8'hC8, 8'h7F, 8'hFF, 8'h80, 8'h0A};
    logic [7:0]  tb_ [16] = '{8'h00, 8'h01, 8'h03, 8'h0F, 8'h10, 8'h01, 8'hFF, 8'h02,
                             8'h34, 8'h55, 8'h64, 8'h03, 8'h7F, 8'hFE, 8'h80, 8'h0B};
    logic [15:0] tp [16] = '{16'h0000, 16'h0001, 16'h0006, 16'h00E1, 16'h0100, 16'h00FF,
                             16'h00FF, 16'h0100, 16'h03A8, 16'h3872, 16'h2710, 16'h0258,
                             16'h3F01, 16'hFD02, 16'h4000, 16'h006E};
    logic [3:0]  w4a [4] = '{4'hF, 4'h3, 4'hA, 4'h8};
    logic [3:0]  w4b [4] = '{4'hF, 4'h5, 4'h7, 4'h8};
    logic [7:0]  w4p [4] = '{8'hE1, 8'h0F, 8'h46, 8'h40};
    logic [15:0] w16a [4] = '{16'hFFFF, 16'h1234, 16'h00FF, 16'h8000};
    logic [15:0] w16b [4] = '{16'hFFFF, 16'h0010, 16'h0101, 16'h0002};
    logic [31:0] w16p [4] = '{32'hFFFE0001, 32'h00012340, 32'h0000FFFF, 32'h00010000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every consumed output
    always @(negedge clk) begin
        if (rst_n) begin
            if (was_stall) check("hold_out", {16'h0, bus.mul_out}, {16'h0, held});
            if (bus.mul_en_out && bus.mul_out_rdy) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
                else check("result", {16'h0, bus.mul_out}, {16'h0, exp_q.pop_front()});
            end else if (!bus.mul_en_out) begin
                check("idle_zero", {16'h0, bus.mul_out}, 32'h0);
            end else begin
                check("stall_rdy_in", {31'h0, bus.mul_rdy_in}, 32'h0);
                stall_cnt <= stall_cnt + 1;
            end
            was_stall <= bus.mul_en_out && !bus.mul_out_rdy;
            held      <= bus.mul_out;
        end else begin
            was_stall <= 1'b0;
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
        int  n = 0;
        logic ok = 1'b0;
        bus.mul_en_in  = 1'b1;
        bus.mul_a      = a;
        bus.mul_b      = b;
        bus.mul_signed = s;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.mul_rdy_in;
            @(posedge clk);
            #1;
            n++;
        end
        if (ok) exp_q.push_back(e);
        else check("issue_accept", {31'h0, ok}, 32'h1);
        bus.mul_en_in = 1'b0;
    endtask

    task automatic lat_check(input logic [15:0] e);
        @(posedge clk); #1;
        check("lat_k1_en", {31'h0, bus.mul_en_out}, 32'h0);
        @(posedge clk); #1;
        check("lat_k2_en", {31'h0, bus.mul_en_out}, 32'h0);
        @(posedge clk); #1;
        check("lat_k3_en", {31'h0, bus.mul_en_out}, 32'h1);
        check("lat_k3_out", {16'h0, bus.mul_out}, {16'h0, e});
        @(posedge clk); #1;
        check("single_cycle", {31'h0, bus.mul_en_out}, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 32'h0);
    endtask

    initial begin
        int c0, s0;
        bus.mul_en_in = 1'b0; bus.mul_a = '0; bus.mul_b = '0; bus.mul_signed = 1'b0; bus.mul_out_rdy = 1'b1;
        bus4.mul_en_in = 1'b0; bus4.mul_a = '0; bus4.mul_b = '0; bus4.mul_signed = 1'b0; bus4.mul_out_rdy = 1'b1;
        bus16.mul_en_in = 1'b0; bus16.mul_a = '0; bus16.mul_b = '0; bus16.mul_signed = 1'b0; bus16.mul_out_rdy = 1'b1;

        // T1 reset with valid asserted
        rst_n = 1'b0;
        bus.mul_en_in = 1'b1; bus.mul_a = 8'h55; bus.mul_b = 8'h33;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en_out", {31'h0, bus.mul_en_out}, 32'h0);
        check("rst_out", {16'h0, bus.mul_out}, 32'h0);
        bus.mul_en_in = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_rst", {31'h0, bus.mul_rdy_in}, 32'h1);
        check("en_out_after_rst", {31'h0, bus.mul_en_out}, 32'h0);

        // T2 max unsigned with latency
        issue(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        lat_check(16'hFE01);

        // T3 back-to-back stream
        c0 = cyc;
        for (int i = 0; i < 16; i++) issue(ta[i], tb_[i], 1'b0, tp[i]);
        check("t3_b2b_accept", cyc - c0, 32'd16);
        drain();

        // T4 signed and mixed modes
        issue(8'h80, 8'h7F, 1'b1, SGN ? 16'hC080 : 16'h3F80);
        issue(8'hFF, 8'hFF, 1'b1, SGN ? 16'h0001 : 16'hFE01);
        issue(8'h05, 8'hFD, 1'b1, SGN ? 16'hFFF1 : 16'h04F1);
        issue(8'hFD, 8'h05, 1'b0, 16'h04F1);
        issue(8'h80, 8'h80, 1'b1, 16'h4000);
        drain();

        // T5 backpressure mid-stream
        s0 = stall_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) issue(ta[i+8], tb_[i+8], 1'b0, tp[i+8]);
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus.mul_out_rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.mul_out_rdy = 1'b1;
            end
        join
        drain();
        check("t5_stall_cycles", stall_cnt - s0, 32'd5);

        // T6 reset with three ops in flight
        issue(8'h11, 8'h11, 1'b0, 16'h0121);
        issue(8'h22, 8'h22, 1'b0, 16'h0484);
        issue(8'h33, 8'h33, 1'b0, 16'h0A29);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        rst_n = 1'b1;
        check("t6_flush_en", {31'h0, bus.mul_en_out}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_output", {31'h0, bus.mul_en_out}, 32'h0);
        issue(8'h12, 8'h34, 1'b0, 16'h03A8);
        lat_check(16'h03A8);

        // WIDTH 4 and 16 streams
        for (int i = 0; i < 4; i++) begin
            bus4.mul_en_in = 1'b1;  bus4.mul_a = w4a[i];   bus4.mul_b = w4b[i];
            bus16.mul_en_in = 1'b1; bus16.mul_a = w16a[i]; bus16.mul_b = w16b[i];
            @(posedge clk); #1;
        end
        bus4.mul_en_in = 1'b0;
        bus16.mul_en_in = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("w4_en", {31'h0, bus4.mul_en_out}, 32'h1);
            check("w4_out", {24'h0, bus4.mul_out}, {24'h0, w4p[j]});
            check("w16_en", {31'h0, bus16.mul_en_out}, 32'h1);
            check("w16_out", bus16.mul_out, w16p[j]);
            @(posedge clk); #1;
        end
        check("w4_idle", {31'h0, bus4.mul_en_out}, 32'h0);
        check("w16_idle", {31'h0, bus16.mul_en_out}, 32'h0);

        drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
